frankencrypt_operand_bank: RTL
==============================

# frankencrypt_operand_bank

Operand/result word store sitting directly behind the FrankenCrypt AXI-Lite register file. It consumes the decoded writes to the control (0x4), address-pointer (0x8) and data-port (0xC) registers and turns them into auto-incrementing word accesses on a shared buffer. It issues one-cycle start pulses to the SHA, AES and RSA cores, and gives the active core exclusive access to the buffer while it runs.

## Interface
Parameters:
- DATA_WIDTH, 32, word width of buffer and register data.
- PTR_WIDTH, 7, pointer width; buffer depth is 2**PTR_WIDTH words. RSA layout is B at 0–31, A at 32–63, N at 64–95, each most-significant word first.

Ports:
- S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- ptr_wr_en  in  1  register 0x8 written this cycle.
- ptr_wr_data  in  DATA_WIDTH  new pointer; low PTR_WIDTH bits are used.
- dp_wr_en  in  1  register 0xC written this cycle.
- dp_wr_data  in  DATA_WIDTH  word to store.
- dp_rd_req  in  1  register 0xC read this cycle.
- dp_rd_data  out  DATA_WIDTH  read word.
- dp_rd_valid  out  1  one-cycle strobe qualifying dp_rd_data.
- ctrl_wr_en  in  1  register 0x4 written this cycle.
- ctrl_wr_data  in  DATA_WIDTH  command word.
- start_sha, start_aes, start_rsa  out  1 each  one-cycle start pulses.
- core_done  in  1  one-cycle pulse from the running core.
- core_addr  in  PTR_WIDTH  core buffer address.
- core_we  in  1  core write enable.
- core_wdata  in  DATA_WIDTH  core write data.
- core_rdata  out  DATA_WIDTH  core read data, one-cycle latency.
- busy  out  1  a core owns the buffer.
- ptr  out  PTR_WIDTH  current pointer, for status readback.
- err  out  1  sticky host-access error.

## Operation
- FSM with 3 states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on a valid command; RUN -> DRAIN on core_done; DRAIN -> IDLE after one cycle.
  - busy = 1 in RUN and DRAIN.
- Command decode on ctrl_wr_en in IDLE, using ctrl_wr_data[31:30] and ctrl_wr_data[0]:
  - 2'b10 -> start_sha.
  - 2'b01 -> start_aes.
  - 2'b11 with bit 0 = 1 -> start_rsa (0xC0000001).
  - 2'b00, or 2'b11 with bit 0 = 0: no-op; state stays IDLE.
- ctrl_wr_en outside IDLE: ignored, err set.
- Host pointer ops (IDLE only):
  - ptr_wr_en loads ptr.
  - dp_wr_en writes buffer[ptr], then ptr++.
  - dp_rd_req reads buffer[ptr], then ptr++.
- ptr wraps from 2**PTR_WIDTH−1 to 0 without error.
- Same-cycle priority: ptr_wr_en > dp_wr_en > dp_rd_req > ctrl_wr_en. Lower-priority requests are dropped and err is set.
- Host ptr/dp ops while busy: dropped, ptr unchanged, err set. A dropped read produces no dp_rd_valid.
- Core port is active only while busy; core_we is ignored in IDLE.
- err clears only on reset, or on a ctrl write with ctrl_wr_data = 0 in IDLE.
- Reset:
  - ptr = 0, state IDLE.
  - All start pulses, dp_rd_valid, busy and err = 0; dp_rd_data = 0, core_rdata = 0.
  - Buffer contents are not cleared.
  - Reset during RUN aborts ownership immediately; a later core_done is ignored.

## Timing
- ptr_wr_en at edge N: ptr shows the new value after edge N.
- dp_wr_en at edge N: the word is readable from edge N+1; ptr increments at edge N.
- dp_rd_req at edge N: dp_rd_data and dp_rd_valid are valid for exactly the cycle after edge N; ptr increments at edge N.
- Back-to-back reads and writes are sustained at 1 word/cycle.
- Command at edge N: start_x is high for the cycle after edge N; busy rises in the same cycle.
- core_done at edge M: state is DRAIN after M and busy drops after edge M+1. A host access accepted at edge M+2 or later succeeds.
- core_addr at edge K: core_rdata is valid after edge K. Core write and read of the same address in one cycle return the old data.

## Test plan
- Write 0 to ptr, then 3 dp writes 0xA, 0xB, 0xC; write 0 to ptr, then 3 dp reads -> 0xA, 0xB, 0xC on consecutive dp_rd_valid strobes; ptr = 3; err = 0.
- Full RSA load: ptr = 0, 96 dp writes (B, A, N) -> ptr = 96. ctrl 0xC0000001 -> single start_rsa pulse, busy = 1. A core read of address 95 returns the N low word.
- While busy, issue a dp write of 0x55 at ptr 96 -> buffer[96] unchanged, ptr = 96, err = 1. After core_done plus 2 cycles the same write succeeds; ctrl 0 clears err.
- ptr = 127, then 2 dp writes 0x1, 0x2 -> buffer[127] = 1, buffer[0] = 2, ptr = 1, no err.
- Same-cycle ptr_wr_en (5) and dp_wr_en (0x9) -> ptr = 5, no buffer write, err = 1. ctrl 0x80000000 -> start_sha only; ctrl 0x40000000 while busy -> no start_aes, err = 1.
- Assert reset mid-RUN -> busy, err, ptr = 0 the next cycle. A subsequent core_done produces no state change, and buffer contents are retained on readback.

Source files
------------

// File: rtl/frankencrypt_operand_bank.sv
// frankencrypt_operand_bank: word buffer behind the FrankenCrypt register file.
// The host streams words through an auto-incrementing pointer while idle.
// A started crypto core owns the buffer through its own port until it signals done.
module frankencrypt_operand_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 7
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic                  ptr_wr_en,
    input  logic [DATA_WIDTH-1:0] ptr_wr_data,
    input  logic                  dp_wr_en,
    input  logic [DATA_WIDTH-1:0] dp_wr_data,
    input  logic                  dp_rd_req,
    output logic [DATA_WIDTH-1:0] dp_rd_data,
    output logic                  dp_rd_valid,
    input  logic                  ctrl_wr_en,
    input  logic [DATA_WIDTH-1:0] ctrl_wr_data,
    output logic                  start_sha,
    output logic                  start_aes,
    output logic                  start_rsa,
    input  logic                  core_done,
    input  logic [PTR_WIDTH-1:0]  core_addr,
    input  logic                  core_we,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  busy,
    output logic [PTR_WIDTH-1:0]  ptr,
    output logic                  err
);

    localparam int DEPTH = 2 ** PTR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [PTR_WIDTH-1:0]  ptr_q;
    logic [PTR_WIDTH-1:0]  ptr_d;
    logic                  err_q;
    logic                  err_d;
    logic                  host_we;
    logic                  host_re;
    logic                  cmd_sha;
    logic                  cmd_aes;
    logic                  cmd_rsa;
    logic                  host_any;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] buf_mem [DEPTH];

    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  rd_vld_p1;
    logic [DATA_WIDTH-1:0] core_rdata_p1;
    logic                  start_sha_p1;
    logic                  start_aes_p1;
    logic                  start_rsa_p1;

    // Only the low pointer bits of a pointer write address the buffer.
    logic unused_ptr_bits;
    assign unused_ptr_bits = ^ptr_wr_data[DATA_WIDTH-1:PTR_WIDTH];

    assign host_any = ptr_wr_en | dp_wr_en | dp_rd_req | ctrl_wr_en;
    assign busy_q   = (state_q != ST_IDLE);

    // Next-state, host request arbitration and command decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
        host_we = 1'b0;
        host_re = 1'b0;
        cmd_sha = 1'b0;
        cmd_aes = 1'b0;
        cmd_rsa = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Highest-priority request wins; anything else asserted alongside it is lost.
                if (ptr_wr_en) begin
                    ptr_d = ptr_wr_data[PTR_WIDTH-1:0];
                    if (dp_wr_en | dp_rd_req | ctrl_wr_en) err_d = 1'b1;
                end else if (dp_wr_en) begin
                    host_we = 1'b1;
                    ptr_d   = ptr_q + PTR_WIDTH'(1);
                    if (dp_rd_req | ctrl_wr_en) err_d = 1'b1;
                end else if (dp_rd_req) begin
                    host_re = 1'b1;
                    ptr_d   = ptr_q + PTR_WIDTH'(1);
                    if (ctrl_wr_en) err_d = 1'b1;
                end else if (ctrl_wr_en) begin
                    if (ctrl_wr_data == '0) err_d = 1'b0;
                    case (ctrl_wr_data[31:30])
                        2'b10:   cmd_sha = 1'b1;
                        2'b01:   cmd_aes = 1'b1;
                        2'b11:   cmd_rsa = ctrl_wr_data[0];
                        default: ;
                    endcase
                    if (cmd_sha | cmd_aes | cmd_rsa) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (core_done) state_d = ST_DRAIN;
                if (host_any)  err_d   = 1'b1;
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
                if (host_any) err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state: FSM, pointer, sticky error, start pulses and read strobe.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            err_q        <= 1'b0;
            rd_vld_p1    <= 1'b0;
            start_sha_p1 <= 1'b0;
            start_aes_p1 <= 1'b0;
            start_rsa_p1 <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            err_q        <= err_d;
            rd_vld_p1    <= host_re;
            start_sha_p1 <= cmd_sha;
            start_aes_p1 <= cmd_aes;
            start_rsa_p1 <= cmd_rsa;
        end
    end

    // Registered read ports; the core port only samples while a core owns the buffer.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_data_p1    <= '0;
            core_rdata_p1 <= '0;
        end else begin
            if (host_re) rd_data_p1 <= buf_mem[ptr_q];
            if (busy_q)  core_rdata_p1 <= buf_mem[core_addr];
        end
    end

    // Buffer write port: host while idle, core while busy; reset blocks both so an aborted run cannot land a write.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESET) begin
            if (host_we) begin
                buf_mem[ptr_q] <= dp_wr_data;
            end else if (busy_q && core_we) begin
                buf_mem[core_addr] <= core_wdata;
            end
        end
    end

    assign dp_rd_data  = rd_data_p1;
    assign dp_rd_valid = rd_vld_p1;
    assign core_rdata  = core_rdata_p1;
    assign start_sha   = start_sha_p1;
    assign start_aes   = start_aes_p1;
    assign start_rsa   = start_rsa_p1;
    assign busy        = busy_q;
    assign ptr         = ptr_q;
    assign err         = err_q;

endmodule
